// File: rtl/lcd_pkg.sv
// Shared types, opcode constants and address-counter helpers for the
// HD44780-compatible responder.
package lcd_pkg;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_BUSY  = 2'd1,
        S_CLEAR = 2'd2
    } lcd_state_e;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISPLAY,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } lcd_op_e;

    localparam logic [7:0] FILL_CHAR = 8'h20;

    localparam logic [7:0] OP_DDRAM_MASK   = 8'h80, OP_DDRAM_MATCH   = 8'h80;
    localparam logic [7:0] OP_CGRAM_MASK   = 8'hC0, OP_CGRAM_MATCH   = 8'h40;
    localparam logic [7:0] OP_FUNC_MASK    = 8'hE0, OP_FUNC_MATCH    = 8'h20;
    localparam logic [7:0] OP_SHIFT_MASK   = 8'hF0, OP_SHIFT_MATCH   = 8'h10;
    localparam logic [7:0] OP_DISPLAY_MASK = 8'hF8, OP_DISPLAY_MATCH = 8'h08;
    localparam logic [7:0] OP_ENTRY_MASK   = 8'hFC, OP_ENTRY_MATCH   = 8'h04;
    localparam logic [7:0] OP_HOME_MASK    = 8'hFE, OP_HOME_MATCH    = 8'h02;
    localparam logic [7:0] OP_CLEAR_MASK   = 8'hFF, OP_CLEAR_MATCH   = 8'h01;

    // Priority follows the position of the leading one.
    function automatic lcd_op_e op_decode(input logic [7:0] d);
        if      ((d & OP_DDRAM_MASK)   == OP_DDRAM_MATCH)   return OP_DDRAM;
        else if ((d & OP_CGRAM_MASK)   == OP_CGRAM_MATCH)   return OP_CGRAM;
        else if ((d & OP_FUNC_MASK)    == OP_FUNC_MATCH)    return OP_FUNC;
        else if ((d & OP_SHIFT_MASK)   == OP_SHIFT_MATCH)   return OP_SHIFT;
        else if ((d & OP_DISPLAY_MASK) == OP_DISPLAY_MATCH) return OP_DISPLAY;
        else if ((d & OP_ENTRY_MASK)   == OP_ENTRY_MATCH)   return OP_ENTRY;
        else if ((d & OP_HOME_MASK)    == OP_HOME_MATCH)    return OP_HOME;
        else if ((d & OP_CLEAR_MASK)   == OP_CLEAR_MATCH)   return OP_CLEAR;
        else                                                return OP_NOP;
    endfunction

    function automatic logic [6:0] ac_inc(input logic [6:0] ac);
        if      (ac == 7'h27) return 7'h40;
        else if (ac == 7'h67) return 7'h00;
        else                  return ac + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] ac);
        if      (ac == 7'h00) return 7'h67;
        else if (ac == 7'h40) return 7'h27;
        else                  return ac - 7'd1;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
        return up ? ac_inc(ac) : ac_dec(ac);
    endfunction

    function automatic logic ac_mapped(input logic [6:0] ac);
        return (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] ac_map(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 DDRAM image: one write port, registered bus and debug read ports.
// Storage has no reset; only the read registers are reset.
module lcd_ddram (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_we,
    input  logic [4:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [4:0] i_bus_addr,
    output logic [7:0] o_bus_data,
    input  logic [4:0] i_dbg_addr,
    output logic [7:0] o_dbg_data
);

    logic [7:0] mem_q [32];
    logic [7:0] bus_q;
    logic [7:0] dbg_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus_q <= '0;
            dbg_q <= '0;
        end else begin
            bus_q <= mem_q[i_bus_addr];
            dbg_q <= mem_q[i_dbg_addr];
        end
    end

    assign o_bus_data = bus_q;
    assign o_dbg_data = dbg_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible display-side responder with busy emulation and debug port.
// Define LCD_RESP_INIT_CHECK_EN to enforce the 8-bit power-on init sequence.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES      = 32,
    parameter int BUSY_LONG_CYCLES = 1312
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_lcd_en,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic [7:0] i_lcd_data,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_data_oe,
    input  logic [4:0] i_dbg_idx,
    output logic [7:0] o_dbg_char,
    output logic       o_busy,
    output logic       o_display_on,
    output logic       o_init_done,
    output logic       o_proto_err
);

    localparam int CNT_MAX = (BUSY_LONG_CYCLES > BUSY_CYCLES) ? BUSY_LONG_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(BUSY_LONG_CYCLES - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       clr_idx_q, clr_idx_d;
    logic [6:0]       ac_q, ac_d;
    logic             id_q, id_d;
    logic             disp_q, disp_d;
    logic             init_q, init_d;
    logic             err_q, err_d;
    logic             en_q;
    logic             oe_q, rs_q, mapped_q;
    logic [7:0]       status_q;
`ifdef LCD_RESP_INIT_CHECK_EN
    logic [1:0]       fs_cnt_q, fs_cnt_d;
`endif

    logic       fall, wr_fall, rd_fall, wr_allowed;
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata, bus_rd;
    lcd_op_e    op;

    assign fall    = en_q & ~i_lcd_en;
    assign wr_fall = fall & ~i_lcd_rw;
    assign rd_fall = fall & i_lcd_rw;
    assign op      = op_decode(i_lcd_data);
    assign o_busy  = (state_q != S_READY);

`ifdef LCD_RESP_INIT_CHECK_EN
    assign wr_allowed = init_q | (~i_lcd_rs & (op == OP_FUNC));
`else
    assign wr_allowed = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_idx_d = clr_idx_q;
        ac_d      = ac_q;
        id_d      = id_q;
        disp_d    = disp_q;
        init_d    = init_q;
        err_d     = err_q;
`ifdef LCD_RESP_INIT_CHECK_EN
        fs_cnt_d  = fs_cnt_q;
`endif
        mem_we    = 1'b0;
        mem_waddr = ac_map(ac_q);
        mem_wdata = i_lcd_data;

        unique case (state_q)
            S_BUSY: begin
                if (cnt_q == '0) state_d = S_READY;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = FILL_CHAR;
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
                    state_d = S_BUSY;
                    cnt_d   = LONG_LOAD;
                end
            end
            default: ;
        endcase

        if (rd_fall && i_lcd_rs) begin
            ac_d = ac_step(ac_q, id_q);
        end

        // Busy is judged on the current state, so an edge in the last busy cycle is rejected.
        if (wr_fall) begin
            if (state_q != S_READY || !wr_allowed) begin
                err_d = 1'b1;
            end else if (i_lcd_rs) begin
                mem_we  = ac_mapped(ac_q);
                ac_d    = ac_step(ac_q, id_q);
                state_d = S_BUSY;
                cnt_d   = SHORT_LOAD;
            end else begin
                state_d = S_BUSY;
                cnt_d   = SHORT_LOAD;
                case (op)
                    OP_DDRAM:   ac_d = i_lcd_data[6:0];
                    OP_CGRAM:   ;
                    OP_FUNC: begin
`ifdef LCD_RESP_INIT_CHECK_EN
                        if (!init_q) begin
                            if (fs_cnt_q == 2'd3) begin
                                if (i_lcd_data[4] && i_lcd_data[3]) init_d = 1'b1;
                            end else begin
                                fs_cnt_d = fs_cnt_q + 2'd1;
                            end
                        end
`else
                        init_d = 1'b1;
`endif
                    end
                    OP_SHIFT: begin
                        if (!i_lcd_data[3]) ac_d = ac_step(ac_q, i_lcd_data[2]);
                    end
                    OP_DISPLAY: disp_d = i_lcd_data[2];
                    OP_ENTRY:   id_d   = i_lcd_data[1];
                    OP_HOME: begin
                        ac_d  = '0;
                        cnt_d = LONG_LOAD;
                    end
                    OP_CLEAR: begin
                        ac_d      = '0;
                        id_d      = 1'b1;
                        state_d   = S_CLEAR;
                        clr_idx_d = '0;
                    end
                    default: state_d = S_READY;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_READY;
            cnt_q     <= '0;
            clr_idx_q <= '0;
            ac_q      <= '0;
            id_q      <= 1'b1;
            disp_q    <= 1'b0;
            init_q    <= 1'b0;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
            oe_q      <= 1'b0;
            rs_q      <= 1'b0;
            mapped_q  <= 1'b0;
            status_q  <= '0;
`ifdef LCD_RESP_INIT_CHECK_EN
            fs_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_idx_q <= clr_idx_d;
            ac_q      <= ac_d;
            id_q      <= id_d;
            disp_q    <= disp_d;
            init_q    <= init_d;
            err_q     <= err_d;
            en_q      <= i_lcd_en;
            oe_q      <= i_lcd_en & i_lcd_rw;
            rs_q      <= i_lcd_rs;
            mapped_q  <= ac_mapped(ac_q);
            status_q  <= {o_busy, ac_q};
`ifdef LCD_RESP_INIT_CHECK_EN
            fs_cnt_q  <= fs_cnt_d;
`endif
        end
    end

    // Write enable is gated by reset so an in-flight clear stops without touching the next entry.
    lcd_ddram u_ddram (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_we       (mem_we & i_rst_n),
        .i_waddr    (mem_waddr),
        .i_wdata    (mem_wdata),
        .i_bus_addr (ac_map(ac_q)),
        .o_bus_data (bus_rd),
        .i_dbg_addr (i_dbg_idx),
        .o_dbg_data (o_dbg_char)
    );

    assign o_lcd_data    = oe_q ? (rs_q ? (mapped_q ? bus_rd : FILL_CHAR) : status_q) : '0;
    assign o_lcd_data_oe = oe_q;
    assign o_display_on  = disp_q;
    assign o_init_done   = init_q;
    assign o_proto_err   = err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed self-checking bench for lcd_hd44780_responder (default build).
module tb_lcd_hd44780_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data_i;
    logic [7:0] lcd_data_o;
    logic       lcd_oe;
    logic [4:0] dbg_idx;
    logic [7:0] dbg_char;
    logic       busy, disp_on, init_done, proto_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcd_hd44780_responder #(
        .BUSY_CYCLES      (32),
        .BUSY_LONG_CYCLES (1312)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_lcd_en      (lcd_en),
        .i_lcd_rs      (lcd_rs),
        .i_lcd_rw      (lcd_rw),
        .i_lcd_data    (lcd_data_i),
        .o_lcd_data    (lcd_data_o),
        .o_lcd_data_oe (lcd_oe),
        .i_dbg_idx     (dbg_idx),
        .o_dbg_char    (dbg_char),
        .o_busy        (busy),
        .o_display_on  (disp_on),
        .o_init_done   (init_done),
        .o_proto_err   (proto_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_i = d; lcd_en = 1'b1;
        @(negedge clk);
        lcd_en = 1'b0;
    endtask

    task automatic bus_rd(input logic rs, output logic [7:0] d, output logic oe);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
        @(negedge clk);
        d = lcd_data_o; oe = lcd_oe;
        lcd_en = 1'b0;
    endtask

    task automatic wait_ready();
        logic [7:0] s;
        logic       oe;
        bit         ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bus_rd(1'b0, s, oe);
            if (!s[7]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_ready_timeout", 16'd0, 16'd1);
    endtask

    task automatic wr_count(input logic rs, input logic [7:0] d, output int n);
        bus_wr(rs, d);
        n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic dbg_rd(input int idx, output logic [7:0] c);
        @(negedge clk);
        dbg_idx = 5'(idx);
        @(negedge clk);
        c = dbg_char;
    endtask

    initial begin
        logic [7:0] s, c;
        logic       oe;
        int         n;

        rst_n = 1'b0; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_data_i = '0; dbg_idx = '0;
        repeat (3) @(negedge clk);
        chk("rst_data",  16'(lcd_data_o), 16'h00);
        chk("rst_oe",    16'(lcd_oe),     16'h0);
        chk("rst_busy",  16'(busy),       16'h0);
        chk("rst_disp",  16'(disp_on),    16'h0);
        chk("rst_init",  16'(init_done),  16'h0);
        chk("rst_err",   16'(proto_err),  16'h0);
        chk("rst_dbg",   16'(dbg_char),   16'h00);
        rst_n = 1'b1;

        // Controller init sequence
        wr_count(1'b0, 8'h38, n);
        chk("fs_busy_cycles", 16'(n), 16'd32);
        chk("init_after_fs", 16'(init_done), 16'h1);
        bus_wr(1'b0, 8'h38); wait_ready();
        bus_wr(1'b0, 8'h38); wait_ready();
        bus_wr(1'b0, 8'h38); wait_ready();
        bus_wr(1'b0, 8'h0C); wait_ready();
        bus_wr(1'b0, 8'h06); wait_ready();
        wr_count(1'b0, 8'h01, n);
        chk("clear_busy_cycles_init", 16'(n), 16'd1344);
        bus_wr(1'b0, 8'h80); wait_ready();
        bus_wr(1'b1, 8'h41); wait_ready();
        dbg_rd(0, c);          chk("ddram0_A", 16'(c), 16'h41);
        bus_rd(1'b0, s, oe);   chk("ac_after_A", 16'(s), 16'h01);
        chk("status_oe", 16'(oe), 16'h1);
        @(negedge clk);        chk("oe_drop", 16'(lcd_oe), 16'h0);
        chk("init_done", 16'(init_done), 16'h1);
        chk("err_clean", 16'(proto_err), 16'h0);
        chk("display_on", 16'(disp_on), 16'h1);

        // End of line 1 and unmapped AC
        bus_wr(1'b0, 8'h8F); wait_ready();
        bus_wr(1'b1, 8'h42); wait_ready();
        dbg_rd(15, c);         chk("ddram15", 16'(c), 16'h42);
        bus_rd(1'b0, s, oe);   chk("ac_0x10", 16'(s), 16'h10);
        bus_wr(1'b1, 8'h55); wait_ready();
        dbg_rd(15, c);         chk("ddram15_kept", 16'(c), 16'h42);
        dbg_rd(16, c);         chk("ddram16_kept", 16'(c), 16'h20);
        bus_rd(1'b0, s, oe);   chk("ac_0x11", 16'(s), 16'h11);

        // Line wrap on increment and decrement
        bus_wr(1'b0, 8'hA7); wait_ready();
        bus_wr(1'b1, 8'h58); wait_ready();
        bus_rd(1'b0, s, oe);   chk("ac_wrap_27_40", 16'(s), 16'h40);
        bus_wr(1'b0, 8'h04); wait_ready();
        bus_wr(1'b0, 8'h80); wait_ready();
        bus_wr(1'b1, 8'h61); wait_ready();
        bus_rd(1'b0, s, oe);   chk("ac_wrap_00_67", 16'(s), 16'h67);
        dbg_rd(0, c);          chk("ddram0_dec", 16'(c), 16'h61);

        // Data read steps AC per I/D (currently decrement)
        bus_wr(1'b0, 8'h8F); wait_ready();
        bus_rd(1'b1, s, oe);   chk("data_read15", 16'(s), 16'h42);
        bus_rd(1'b0, s, oe);   chk("ac_after_read", 16'(s), 16'h0E);
        bus_wr(1'b0, 8'h06); wait_ready();

        // Write while busy is rejected
        bus_wr(1'b0, 8'h85); wait_ready();
        bus_wr(1'b1, 8'h5A);
        bus_rd(1'b0, s, oe);   chk("bf_read_busy", 16'(s), 16'h86);
        bus_wr(1'b0, 8'h08);
        wait_ready();
        chk("disp_unchanged", 16'(disp_on), 16'h1);
        chk("proto_err_set", 16'(proto_err), 16'h1);
        dbg_rd(5, c);          chk("ddram5", 16'(c), 16'h5A);

        // Full clear
        wr_count(1'b0, 8'h01, n);
        chk("clear_busy_cycles", 16'(n), 16'd1344);
        for (int i = 0; i < 32; i++) begin
            dbg_rd(i, c);
            chk($sformatf("clear_entry%0d", i), 16'(c), 16'h20);
        end
        bus_rd(1'b0, s, oe);   chk("ac_after_clear", 16'(s), 16'h00);

        // Fill every entry with a distinct value
        bus_wr(1'b0, 8'h80); wait_ready();
        for (int i = 0; i < 32; i++) begin
            if (i == 16) begin
                bus_wr(1'b0, 8'hC0); wait_ready();
            end
            bus_wr(1'b1, 8'(8'h41 + i)); wait_ready();
        end

        // Reset while the clear is about to write entry 10
        bus_wr(1'b0, 8'h01);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("busy_after_reset", 16'(busy), 16'h0);
        chk("err_after_reset", 16'(proto_err), 16'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dbg_rd(i, c);
            chk($sformatf("partial_entry%0d", i), 16'(c),
                (i < 10) ? 16'h20 : 16'(8'h41 + i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
